// File: rtl/amo_issue_pkg.sv
// Shared types and constants for the AMO issue stage: FSM state encoding,
// payload widths, the captured request struct and default parameter values.
package amo_issue_pkg;

    localparam int CMD_W   = 5;
    localparam int VADDR_W = 39;
    localparam int PADDR_W = 36;
    localparam int WIDX_W  = 3;
    localparam int DATA_W  = 64;
    localparam int MASK_W  = 8;

    // Replay and backoff counters are both 4 bits; 15 is the saturation point.
    localparam int CNT_W = 4;

    localparam int unsigned DEF_BACKOFF_CYCLES = 4;
    localparam int unsigned DEF_MAX_REPLAYS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [VADDR_W-1:0] vaddr;
        logic [PADDR_W-1:0] addr;
        logic [WIDX_W-1:0]  word_idx;
        logic [DATA_W-1:0]  amo_data;
        logic [MASK_W-1:0]  amo_mask;
    } amo_req_t;

endpackage

// File: rtl/amo_issue_stage_backoff_ctr.sv
// Backoff down-counter: load sets the count, tick decrements it, done flags
// the final cycle of the backoff window (count == 1).
module amo_backoff_ctr
    import amo_issue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/amo_issue_stage.sv
// AMO issue stage: one outstanding atomic into the main pipe, with replay
// backoff. Optional replay cap is built when AMO_REPLAY_LIMIT_EN is defined.
module amo_issue_stage
    import amo_issue_pkg::*;
#(
    parameter int unsigned BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
    parameter int unsigned MAX_REPLAYS    = DEF_MAX_REPLAYS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_req_valid,
    output logic               io_req_ready,
    input  logic [CMD_W-1:0]   io_req_bits_cmd,
    input  logic [VADDR_W-1:0] io_req_bits_vaddr,
    input  logic [PADDR_W-1:0] io_req_bits_addr,
    input  logic [WIDX_W-1:0]  io_req_bits_word_idx,
    input  logic [DATA_W-1:0]  io_req_bits_amo_data,
    input  logic [MASK_W-1:0]  io_req_bits_amo_mask,
    output logic               io_pipe_req_valid,
    input  logic               io_pipe_req_ready,
    output logic [CMD_W-1:0]   io_pipe_req_bits_cmd,
    output logic [VADDR_W-1:0] io_pipe_req_bits_vaddr,
    output logic [PADDR_W-1:0] io_pipe_req_bits_addr,
    output logic [WIDX_W-1:0]  io_pipe_req_bits_word_idx,
    output logic [DATA_W-1:0]  io_pipe_req_bits_amo_data,
    output logic [MASK_W-1:0]  io_pipe_req_bits_amo_mask,
    input  logic               io_pipe_resp_valid,
    input  logic               io_pipe_resp_bits_replay,
    input  logic [DATA_W-1:0]  io_pipe_resp_bits_data,
    input  logic               io_pipe_resp_bits_error,
    output logic               io_resp_valid,
    input  logic               io_resp_ready,
    output logic [DATA_W-1:0]  io_resp_bits_data,
    output logic               io_resp_bits_error,
    output logic               io_busy
);

    if (BACKOFF_CYCLES < 1 || BACKOFF_CYCLES > 15 || MAX_REPLAYS < 1 || MAX_REPLAYS > 15) begin : g_bad_param
        $error("amo_issue_stage: BACKOFF_CYCLES and MAX_REPLAYS must be in 1..15");
    end

    state_e            state_q, state_d;
    amo_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [CNT_W-1:0]  replay_q, replay_d, replay_inc;
    logic              bo_load, bo_done;

    assign replay_inc = (replay_q == '1) ? replay_q : replay_q + 1'b1;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; valid never depends on ready in this block.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        replay_d = replay_q;
        bo_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_req_valid) begin
                    req_d = '{cmd:      io_req_bits_cmd,
                              vaddr:    io_req_bits_vaddr,
                              addr:     io_req_bits_addr,
                              word_idx: io_req_bits_word_idx,
                              amo_data: io_req_bits_amo_data,
                              amo_mask: io_req_bits_amo_mask};
                    replay_d = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (io_pipe_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (io_pipe_resp_valid) begin
                    if (io_pipe_resp_bits_replay) begin
                        replay_d = replay_inc;
`ifdef AMO_REPLAY_LIMIT_EN
                        if (replay_inc == CNT_W'(MAX_REPLAYS)) begin
                            rdata_d = '0;
                            rerr_d  = 1'b1;
                            state_d = ST_RESP;
                        end else begin
                            bo_load = 1'b1;
                            state_d = ST_BACKOFF;
                        end
`else
                        bo_load = 1'b1;
                        state_d = ST_BACKOFF;
`endif
                    end else begin
                        rdata_d = io_pipe_resp_bits_data;
                        rerr_d  = io_pipe_resp_bits_error;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BACKOFF: begin
                if (bo_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (io_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            replay_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            replay_q <= replay_d;
        end
    end

    amo_backoff_ctr u_backoff (
        .clock (clock),
        .reset (reset),
        .load  (bo_load),
        .value (CNT_W'(BACKOFF_CYCLES)),
        .tick  (state_q == ST_BACKOFF),
        .done  (bo_done)
    );

    assign io_req_ready      = (state_q == ST_IDLE);
    assign io_pipe_req_valid = (state_q == ST_ISSUE);
    assign io_resp_valid     = (state_q == ST_RESP);
    assign io_busy           = (state_q != ST_IDLE);

    assign io_pipe_req_bits_cmd      = req_q.cmd;
    assign io_pipe_req_bits_vaddr    = req_q.vaddr;
    assign io_pipe_req_bits_addr     = req_q.addr;
    assign io_pipe_req_bits_word_idx = req_q.word_idx;
    assign io_pipe_req_bits_amo_data = req_q.amo_data;
    assign io_pipe_req_bits_amo_mask = req_q.amo_mask;
    assign io_resp_bits_data         = rdata_q;
    assign io_resp_bits_error        = rerr_q;

endmodule

// File: tb/tb_amo_issue_stage.sv
// Self-checking bench for amo_issue_stage: directed scenarios with a response
// scoreboard; the replay-limit scenario follows AMO_REPLAY_LIMIT_EN.
module tb_amo_issue_stage;
    import amo_issue_pkg::*;

    localparam int BO = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               io_req_valid = 1'b0;
    logic               io_req_ready;
    logic [CMD_W-1:0]   io_req_bits_cmd = '0;
    logic [VADDR_W-1:0] io_req_bits_vaddr = '0;
    logic [PADDR_W-1:0] io_req_bits_addr = '0;
    logic [WIDX_W-1:0]  io_req_bits_word_idx = '0;
    logic [DATA_W-1:0]  io_req_bits_amo_data = '0;
    logic [MASK_W-1:0]  io_req_bits_amo_mask = '0;
    logic               io_pipe_req_valid;
    logic               io_pipe_req_ready = 1'b0;
    logic [CMD_W-1:0]   io_pipe_req_bits_cmd;
    logic [VADDR_W-1:0] io_pipe_req_bits_vaddr;
    logic [PADDR_W-1:0] io_pipe_req_bits_addr;
    logic [WIDX_W-1:0]  io_pipe_req_bits_word_idx;
    logic [DATA_W-1:0]  io_pipe_req_bits_amo_data;
    logic [MASK_W-1:0]  io_pipe_req_bits_amo_mask;
    logic               io_pipe_resp_valid = 1'b0;
    logic               io_pipe_resp_bits_replay = 1'b0;
    logic [DATA_W-1:0]  io_pipe_resp_bits_data = '0;
    logic               io_pipe_resp_bits_error = 1'b0;
    logic               io_resp_valid;
    logic               io_resp_ready = 1'b0;
    logic [DATA_W-1:0]  io_resp_bits_data;
    logic               io_resp_bits_error;
    logic               io_busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W:0] exp_q[$];

    always #5 clock = ~clock;

    amo_issue_stage #(.BACKOFF_CYCLES(BO), .MAX_REPLAYS(3)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .io_req_valid              (io_req_valid),
        .io_req_ready              (io_req_ready),
        .io_req_bits_cmd           (io_req_bits_cmd),
        .io_req_bits_vaddr         (io_req_bits_vaddr),
        .io_req_bits_addr          (io_req_bits_addr),
        .io_req_bits_word_idx      (io_req_bits_word_idx),
        .io_req_bits_amo_data      (io_req_bits_amo_data),
        .io_req_bits_amo_mask      (io_req_bits_amo_mask),
        .io_pipe_req_valid         (io_pipe_req_valid),
        .io_pipe_req_ready         (io_pipe_req_ready),
        .io_pipe_req_bits_cmd      (io_pipe_req_bits_cmd),
        .io_pipe_req_bits_vaddr    (io_pipe_req_bits_vaddr),
        .io_pipe_req_bits_addr     (io_pipe_req_bits_addr),
        .io_pipe_req_bits_word_idx (io_pipe_req_bits_word_idx),
        .io_pipe_req_bits_amo_data (io_pipe_req_bits_amo_data),
        .io_pipe_req_bits_amo_mask (io_pipe_req_bits_amo_mask),
        .io_pipe_resp_valid        (io_pipe_resp_valid),
        .io_pipe_resp_bits_replay  (io_pipe_resp_bits_replay),
        .io_pipe_resp_bits_data    (io_pipe_resp_bits_data),
        .io_pipe_resp_bits_error   (io_pipe_resp_bits_error),
        .io_resp_valid             (io_resp_valid),
        .io_resp_ready             (io_resp_ready),
        .io_resp_bits_data         (io_resp_bits_data),
        .io_resp_bits_error        (io_resp_bits_error),
        .io_busy                   (io_busy)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic amo_req_t pipe_payload();
        amo_req_t p;
        p.cmd      = io_pipe_req_bits_cmd;
        p.vaddr    = io_pipe_req_bits_vaddr;
        p.addr     = io_pipe_req_bits_addr;
        p.word_idx = io_pipe_req_bits_word_idx;
        p.amo_data = io_pipe_req_bits_amo_data;
        p.amo_mask = io_pipe_req_bits_amo_mask;
        return p;
    endfunction

    function automatic amo_req_t rand_req();
        amo_req_t r;
        r.cmd      = CMD_W'($urandom_range(0, 31));
        r.vaddr    = VADDR_W'({$urandom, $urandom});
        r.addr     = PADDR_W'({$urandom, $urandom});
        r.word_idx = WIDX_W'($urandom_range(0, 7));
        r.amo_data = {$urandom, $urandom};
        r.amo_mask = MASK_W'($urandom_range(1, 255));
        return r;
    endfunction

    task automatic drive_req_bits(input amo_req_t r);
        io_req_bits_cmd      = r.cmd;
        io_req_bits_vaddr    = r.vaddr;
        io_req_bits_addr     = r.addr;
        io_req_bits_word_idx = r.word_idx;
        io_req_bits_amo_data = r.amo_data;
        io_req_bits_amo_mask = r.amo_mask;
    endtask

    task automatic send_req(input amo_req_t r);
        io_req_valid = 1'b1;
        drive_req_bits(r);
        for (int i = 0; i < 20 && !io_req_ready; i++) step();
        check("req_ready_wait", 160'(io_req_ready), 160'(1));
        step();
        io_req_valid = 1'b0;
        drive_req_bits(rand_req());
        check("pipe_valid_latency", 160'(io_pipe_req_valid), 160'(1));
        check("pipe_payload", 160'(pipe_payload()), 160'(r));
    endtask

    task automatic accept_issue();
        io_pipe_req_ready = 1'b1;
        step();
        io_pipe_req_ready = 1'b0;
        check("pipe_valid_after_fire", 160'(io_pipe_req_valid), 160'(0));
    endtask

    task automatic pipe_resp(input logic replay, input logic [DATA_W-1:0] data, input logic err);
        io_pipe_resp_valid       = 1'b1;
        io_pipe_resp_bits_replay = replay;
        io_pipe_resp_bits_data   = data;
        io_pipe_resp_bits_error  = err;
        if (!replay) exp_q.push_back({err, data});
        step();
        io_pipe_resp_valid       = 1'b0;
        io_pipe_resp_bits_replay = 1'b0;
        if (!replay) check("resp_valid_latency", 160'(io_resp_valid), 160'(1));
    endtask

    task automatic wait_backoff(input amo_req_t r);
        int n;
        n = 0;
        while (!io_pipe_req_valid && n < 50) begin
            n++;
            step();
        end
        check("backoff_len", 160'(n), 160'(BO));
        check("reissue_payload", 160'(pipe_payload()), 160'(r));
    endtask

    task automatic collect();
        logic [DATA_W:0] e;
        for (int i = 0; i < 50 && !io_resp_valid; i++) step();
        check("resp_wait", 160'(io_resp_valid), 160'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp_data", 160'(io_resp_bits_data), 160'(e[DATA_W-1:0]));
            check("resp_error", 160'(io_resp_bits_error), 160'(e[DATA_W]));
        end else begin
            check("resp_unexpected", 160'(io_resp_valid), 160'(0));
        end
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
    endtask

    initial begin
        amo_req_t r;
        logic [DATA_W-1:0] d;

        // Reset values
        step();
        step();
        check("rst_req_ready", 160'(io_req_ready), 160'(1));
        check("rst_pipe_valid", 160'(io_pipe_req_valid), 160'(0));
        check("rst_resp_valid", 160'(io_resp_valid), 160'(0));
        check("rst_busy", 160'(io_busy), 160'(0));
        check("rst_payload", 160'(pipe_payload()), 160'(0));
        check("rst_resp_bits", 160'({io_resp_bits_error, io_resp_bits_data}), 160'(0));
        reset = 1'b1;
        step();

        // Single AMO, no replay
        r = rand_req();
        send_req(r);
        accept_issue();
        step();
        check("wait_busy", 160'(io_busy), 160'(1));
        pipe_resp(1'b0, 64'hDEAD_BEEF, 1'b0);
        collect();
        check("idle_after_resp", 160'(io_busy), 160'(0));

        // Pipe backpressure for 10 cycles, with a stray response while in ISSUE
        r = rand_req();
        send_req(r);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 160'(io_pipe_req_valid), 160'(1));
            check("stall_payload", 160'(pipe_payload()), 160'(r));
            io_pipe_resp_valid = (i == 5);
            step();
        end
        io_pipe_resp_valid = 1'b0;
        check("stall_no_resp", 160'(io_resp_valid), 160'(0));
        accept_issue();
        d = {$urandom, $urandom};
        pipe_resp(1'b0, d, 1'b1);
        collect();

        // Two replays then completion
        r = rand_req();
        send_req(r);
        accept_issue();
        for (int k = 0; k < 2; k++) begin
            pipe_resp(1'b1, 64'h0, 1'b0);
            check("replay_no_resp", 160'(io_resp_valid), 160'(0));
            wait_backoff(r);
            accept_issue();
        end
        d = {$urandom, $urandom};
        pipe_resp(1'b0, d, 1'b0);
        collect();

        // Always replay: cap at MAX_REPLAYS=3 when the limit is built in
        r = rand_req();
        send_req(r);
        accept_issue();
        for (int k = 0; k < 2; k++) begin
            pipe_resp(1'b1, 64'h1234, 1'b0);
            wait_backoff(r);
            accept_issue();
        end
`ifdef AMO_REPLAY_LIMIT_EN
        exp_q.push_back({1'b1, 64'h0});
        pipe_resp(1'b1, 64'h1234, 1'b0);
        check("limit_resp_valid", 160'(io_resp_valid), 160'(1));
        collect();
`else
        pipe_resp(1'b1, 64'h1234, 1'b0);
        check("nolimit_no_resp", 160'(io_resp_valid), 160'(0));
        wait_backoff(r);
        accept_issue();
        d = {$urandom, $urandom};
        pipe_resp(1'b0, d, 1'b0);
        collect();
`endif

        // Response backpressure with a new request waiting
        r = rand_req();
        send_req(r);
        accept_issue();
        d = {$urandom, $urandom};
        pipe_resp(1'b0, d, 1'b0);
        io_req_valid = 1'b1;
        drive_req_bits(rand_req());
        for (int i = 0; i < 5; i++) begin
            check("resp_hold_req_ready", 160'(io_req_ready), 160'(0));
            check("resp_hold_valid", 160'(io_resp_valid), 160'(1));
            check("resp_hold_data", 160'(io_resp_bits_data), 160'(d));
            step();
        end
        collect();
        check("no_same_cycle_accept", 160'(io_busy), 160'(0));
        check("no_same_cycle_issue", 160'(io_pipe_req_valid), 160'(0));
        io_req_valid = 1'b0;
        step();

        // Reset during WAIT, then a stray response
        r = rand_req();
        send_req(r);
        accept_issue();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_busy", 160'(io_busy), 160'(0));
        check("async_rst_req_ready", 160'(io_req_ready), 160'(1));
        step();
        reset = 1'b1;
        step();
        io_pipe_resp_valid = 1'b1;
        io_pipe_resp_bits_data = 64'hBAD;
        step();
        io_pipe_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_resp", 160'(io_resp_valid), 160'(0));
            check("stray_idle", 160'(io_req_ready), 160'(1));
            step();
        end

        check("scoreboard_empty", 160'(exp_q.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
